bin2bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one bit per enabled cycle.

---
 rtl/bin2bcd_seq.sv | 109 ++++++++++
 tb/tb_bin2bcd_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to packed BCD converter
module bin2bcd_seq #(
  parameter int BITS_NUM = 14,
  parameter int DIGITS   = 4
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  CE,
  input  logic                  START,
  input  logic [BITS_NUM-1:0]   BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVF,
  output logic [4*DIGITS-1:0]   BCD
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int TOT_W = SCR_W + BITS_NUM;
  localparam int CNT_W = $clog2(BITS_NUM + 1);

  // 10**DIGITS evaluated at full 64-bit width so the limit is never truncated
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0]       LIMIT = pow10(DIGITS);
  localparam logic [SCR_W-1:0]  SAT   = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t               state;
  logic [BITS_NUM-1:0]  shift_reg;
  logic [SCR_W-1:0]     scratch;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 ovf_cap;

  logic [SCR_W-1:0]     adj;
  logic [TOT_W-1:0]     shifted;
  logic [SCR_W-1:0]     scratch_nxt;
  logic [BITS_NUM-1:0]  shift_nxt;
  logic [63:0]          bin_wide;

  // One double-dabble step: add 3 to every digit >= 5, then shift the pair left by one
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    shifted     = {adj, shift_reg} << 1;
    scratch_nxt = shifted[TOT_W-1:BITS_NUM];
    shift_nxt   = shifted[BITS_NUM-1:0];
    bin_wide    = {{(64-BITS_NUM){1'b0}}, BIN};
  end

  // Conversion FSM; results only change in FINISH so BCD/OVF never show partial values
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      ovf_cap   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      OVF       <= 1'b0;
      BCD       <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (CE && START) begin
            shift_reg <= BIN;
            scratch   <= '0;
            bit_cnt   <= CNT_W'(BITS_NUM);
            ovf_cap   <= (bin_wide >= LIMIT);
            BUSY      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (CE) begin
            scratch   <= scratch_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt - CNT_W'(1);
            if (bit_cnt == CNT_W'(1)) begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          BCD   <= ovf_cap ? SAT : scratch;
          OVF   <= ovf_cap;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        clr, ce, start;
  logic [13:0] bin;
  logic        busy, done, ovf;
  logic [15:0] bcd;

  int n_cmp  = 0;
  int n_fail = 0;

  bin2bcd_seq #(.BITS_NUM(14), .DIGITS(4)) dut (
    .CLK(clk), .CLR(clr), .CE(ce), .START(start), .BIN(bin),
    .BUSY(busy), .DONE(done), .OVF(ovf), .BCD(bcd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input logic [13:0] v);
    bin   = v;
    start = 1'b1;
    ce    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // waits for DONE with CE=1; n=-1 on timeout; flags BUSY drop or BCD change before DONE
  task automatic wait_done(input int max, output int n, output bit busy_ok, output bit stable);
    logic [15:0] snap;
    bit found;
    snap = bcd; n = -1; busy_ok = 1'b1; stable = 1'b1; found = 1'b0;
    for (int i = 1; i <= max && !found; i++) begin
      tick();
      if (done) begin
        n = i; found = 1'b1;
      end else begin
        if (!busy) busy_ok = 1'b0;
        if (bcd !== snap) stable = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; ce = 1'b1; start = 1'b0; bin = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({bcd, ovf, busy, done} !== 19'h0) begin
        n_fail++;
        $display("FAIL reset_cyc%0d: got bcd=%h ovf=%b busy=%b done=%b expected all 0", i, bcd, ovf, busy, done);
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_zero();
    int n; bit bok, stb;
    start_conv(14'd0);
    wait_done(100, n, bok, stb);
    n_cmp++;
    if (n !== 15 || !bok) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d busy_ok=%b expected 15 busy_ok=1", n, bok);
    end
    n_cmp++;
    if ({bcd, ovf, busy} !== {16'h0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_result: got bcd=%h ovf=%b busy=%b expected 0000 0 0", bcd, ovf, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done_width: got done=%b expected 0", done);
    end
  endtask

  task automatic test_values();
    logic [13:0] vin [2]  = '{14'd9876, 14'd9999};
    logic [15:0] vexp [2] = '{16'h9876, 16'h9999};
    int n; bit bok, stb;
    for (int i = 0; i < 2; i++) begin
      start_conv(vin[i]);
      wait_done(100, n, bok, stb);
      n_cmp++;
      if (n !== 15 || !stb) begin
        n_fail++;
        $display("FAIL val%0d_latency: got %0d stable=%b expected 15 stable=1", i, n, stb);
      end
      n_cmp++;
      if ({bcd, ovf} !== {vexp[i], 1'b0}) begin
        n_fail++;
        $display("FAIL val%0d_result: got %h ovf=%b expected %h ovf=0", i, bcd, ovf, vexp[i]);
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    logic [13:0] vin [3]  = '{14'd10000, 14'd16383, 14'd42};
    logic [15:0] vexp [3] = '{16'h9999, 16'h9999, 16'h0042};
    logic        vovf [3] = '{1'b1, 1'b1, 1'b0};
    int n; bit bok, stb;
    for (int i = 0; i < 3; i++) begin
      start_conv(vin[i]);
      wait_done(100, n, bok, stb);
      n_cmp++;
      if (n !== 15 || {bcd, ovf} !== {vexp[i], vovf[i]}) begin
        n_fail++;
        $display("FAIL ovf%0d: got n=%0d bcd=%h ovf=%b expected n=15 bcd=%h ovf=%b", i, n, bcd, ovf, vexp[i], vovf[i]);
      end
      tick();
    end
  endtask

  task automatic test_ce_duty();
    int n, dones;
    bit found;
    // START with CE low must not be remembered
    bin = 14'd77; start = 1'b1; ce = 1'b0;
    tick();
    start = 1'b0; ce = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ce_low_start: got busy=%b expected 0", busy);
    end
    // 1-of-4 CE with START held high throughout BUSY
    bin = 14'd1234; start = 1'b1; ce = 1'b1;
    tick();
    n = -1; dones = 0; found = 1'b0;
    for (int i = 1; i <= 300 && !found; i++) begin
      ce = (i % 4 == 0);
      tick();
      if (done) begin
        dones++; n = i; found = 1'b1;
        start = 1'b0;
      end
    end
    n_cmp++;
    if (n !== 57 || dones !== 1) begin
      n_fail++;
      $display("FAIL ce_latency: got n=%0d dones=%0d expected n=57 dones=1", n, dones);
    end
    n_cmp++;
    if ({bcd, ovf} !== {16'h1234, 1'b0}) begin
      n_fail++;
      $display("FAIL ce_result: got %h ovf=%b expected 1234 ovf=0", bcd, ovf);
    end
    ce = 1'b1;
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL ce_done_width: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_clr_abort();
    int n, dones; bit bok, stb;
    start_conv(14'd5555);
    for (int i = 0; i < 6; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++;
    if ({bcd, ovf, busy, done} !== 19'h0) begin
      n_fail++;
      $display("FAIL clr_abort: got bcd=%h ovf=%b busy=%b done=%b expected all 0", bcd, ovf, busy, done);
    end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL clr_no_done: got %0d pulses expected 0", dones);
    end
    start_conv(14'd5555);
    wait_done(100, n, bok, stb);
    n_cmp++;
    if (n !== 15 || bcd !== 16'h5555) begin
      n_fail++;
      $display("FAIL clr_restart: got n=%0d bcd=%h expected n=15 bcd=5555", n, bcd);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n; bit bok, stb;
    start_conv(14'd1);
    wait_done(100, n, bok, stb);
    n_cmp++;
    if (n !== 15 || bcd !== 16'h0001) begin
      n_fail++;
      $display("FAIL b2b_first: got n=%0d bcd=%h expected n=15 bcd=0001", n, bcd);
    end
    // accept during the DONE cycle
    start_conv(14'd2);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b expected 1", busy);
    end
    for (int i = 0; i < 14; i++) tick();
    // now in FINISH: this START must be ignored
    bin = 14'd7; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({done, bcd} !== {1'b1, 16'h0002}) begin
      n_fail++;
      $display("FAIL b2b_second: got done=%b bcd=%h expected 1 0002", done, bcd);
    end
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL finish_start_ignored: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  initial begin
    clr = 1'b0; ce = 1'b0; start = 1'b0; bin = '0;
    tick();
    test_reset();
    test_zero();
    test_values();
    test_overflow();
    test_ce_duty();
    test_clr_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
